lane_valid_tracker: RTL

Consumer-side counterpart of the vector lane valid-mask generator. It takes per-lane valid masks, one beat at a time, from the lanes or the write-back path. It counts accepted elements against the loaded vector length `vl`, pulses completion when the whole vector has arrived, and, when enabled, checks every beat's mask against the mask the generator must have produced. It sits at the collection end of the vector datapath, before the scalar/commit handshake.

---
 rtl/lane_valid_tracker_if.sv | 38 +++
 rtl/lane_valid_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lane_valid_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : lane_valid_tracker_if
//  Brief    : Beat/mask bus between the lane write-back path (master) and
//             the lane valid tracker (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface lane_valid_tracker_if #(
   parameter int MAX_VL_PER_LANE = 256,
   parameter int VLANE_NUM       = 8
);
   localparam int VL_W   = $clog2(VLANE_NUM * MAX_VL_PER_LANE);
   localparam int ELEM_W = VL_W + 1;
   localparam int BEAT_W = $clog2(MAX_VL_PER_LANE) + 1;

   logic [VL_W-1:0]      vl_i;
   logic                 start_i;
   logic                 beat_i;
   logic [VLANE_NUM-1:0] valid_i;
   logic                 ready_o;
   logic                 busy_o;
   logic                 done_o;
   logic [ELEM_W-1:0]    elem_cnt_o;
   logic [BEAT_W-1:0]    beat_cnt_o;
   logic                 err_o;
   logic [1:0]           err_code_o;

   modport master (
      output vl_i, start_i, beat_i, valid_i,
      input  ready_o, busy_o, done_o, elem_cnt_o, beat_cnt_o, err_o, err_code_o
   );

   modport slave (
      input  vl_i, start_i, beat_i, valid_i,
      output ready_o, busy_o, done_o, elem_cnt_o, beat_cnt_o, err_o, err_code_o
   );
endinterface
`default_nettype wire

// File: rtl/lane_valid_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : lane_valid_tracker
//  Brief    : Counts per-lane valid-mask beats against a loaded vector length,
//             pulses done when the vector has fully arrived and, optionally,
//             checks each beat against the mask the generator must produce.
//  Option   : LANE_VALID_TRACKER_MASK_CHECK_EN enables the expected-mask
//             check, the ERR state and err_o / err_code_o.
//  Revision : 1.0  initial release
// ============================================================================
module lane_valid_tracker #(
   parameter int MAX_VL_PER_LANE = 256,
   parameter int VLANE_NUM       = 8
) (
   input  wire logic           clk_i,
   input  wire logic           rst_i,
   lane_valid_tracker_if.slave bus
);
   localparam int VL_W     = $clog2(VLANE_NUM * MAX_VL_PER_LANE);
   localparam int ELEM_W   = VL_W + 1;
   localparam int BEAT_W   = $clog2(MAX_VL_PER_LANE) + 1;
   localparam int LANE_LOG = $clog2(VLANE_NUM);
   localparam int POP_W    = LANE_LOG + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   function automatic logic [POP_W-1:0] popcount(input logic [VLANE_NUM-1:0] m);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < VLANE_NUM; i++) begin
         c = c + POP_W'(m[i]);
      end
      return c;
   endfunction

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [ELEM_W-1:0] r_elem_cnt;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic              w_accept;
   logic [POP_W-1:0]  w_pop;
   logic [ELEM_W-1:0] w_elem_next;
   logic              w_beat_ends;
   logic              w_beat_bad;

   // A beat is taken only in RUN and never in the same cycle as a restart.
   assign w_accept    = (r_state == S_RUN) && bus.beat_i && !bus.start_i;
   assign w_pop       = popcount(bus.valid_i);
   assign w_elem_next = r_elem_cnt + ELEM_W'(w_pop);

`ifdef LANE_VALID_TRACKER_MASK_CHECK_EN
   localparam int DIV_W = VL_W - LANE_LOG;

   logic [DIV_W-1:0]     r_div;
   logic [LANE_LOG-1:0]  r_mod;
   logic [VLANE_NUM-1:0] r_last_mask;
   logic [VLANE_NUM-1:0] w_load_last_mask;
   logic [BEAT_W-1:0]    w_final_idx;
   logic [VLANE_NUM-1:0] w_exp_mask;
   logic                 w_is_prefix;
   logic                 w_is_hole;
   logic [1:0]           w_err_code;
   logic                 r_err;
   logic [1:0]           r_err_code;

   // Partial mask of the tail beat: the low (vl mod lanes) bits set.
   always_comb begin
      w_load_last_mask = '0;
      for (int i = 0; i < VLANE_NUM; i++) begin
         w_load_last_mask[i] = (LANE_LOG'(i) < bus.vl_i[LANE_LOG-1:0]);
      end
   end

   // Expected mask of the current beat and classification of a mismatch.
   always_comb begin
      w_final_idx = (r_mod == '0) ? (BEAT_W'(r_div) - BEAT_W'(1)) : BEAT_W'(r_div);
      w_exp_mask  = (r_beat_cnt < BEAT_W'(r_div)) ? '1 : r_last_mask;
      w_is_prefix = (((bus.valid_i + VLANE_NUM'(1)) & bus.valid_i) == '0);
      w_is_hole   = !w_is_prefix || (bus.valid_i == '0);
      if (w_is_hole) begin
         w_err_code = 2'b01;
      end else if (w_pop > popcount(w_exp_mask)) begin
         w_err_code = 2'b10;
      end else begin
         w_err_code = 2'b11;
      end
      w_beat_bad  = (bus.valid_i != w_exp_mask);
      w_beat_ends = (r_beat_cnt == w_final_idx);
   end

   // Vector geometry captured at start for the per-beat expectation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_div       <= '0;
         r_mod       <= '0;
         r_last_mask <= '0;
      end else if (bus.start_i) begin
         r_div       <= bus.vl_i[VL_W-1:LANE_LOG];
         r_mod       <= bus.vl_i[LANE_LOG-1:0];
         r_last_mask <= w_load_last_mask;
      end
   end

   // Sticky error flag and class; cleared only by start or reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else if (bus.start_i) begin
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else if (w_accept && w_beat_bad) begin
         r_err      <= 1'b1;
         r_err_code <= w_err_code;
      end
   end

   assign bus.err_o      = r_err;
   assign bus.err_code_o = r_err_code;
`else
   logic [VL_W-1:0] r_vl;

   // Without the check, completion is by element count; the beat bound
   // keeps a short-masked stream from running past the per-lane depth.
   always_comb begin
      w_beat_bad  = 1'b0;
      w_beat_ends = (w_elem_next >= ELEM_W'(r_vl)) ||
                    (r_beat_cnt == BEAT_W'(MAX_VL_PER_LANE - 1));
   end

   // Vector length captured at start for the element-count completion.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vl <= '0;
      end else if (bus.start_i) begin
         r_vl <= bus.vl_i;
      end
   end

   assign bus.err_o      = 1'b0;
   assign bus.err_code_o = 2'b00;
`endif

   // Next-state selection; start wins over any beat in every state.
   always_comb begin
      w_state_next = r_state;
      if (bus.start_i) begin
         w_state_next = (bus.vl_i == '0) ? S_DONE : S_RUN;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_accept) begin
                  if (w_beat_bad) begin
                     w_state_next = S_ERR;
                  end else if (w_beat_ends) begin
                     w_state_next = S_DONE;
                  end
               end
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Element and beat counters; mismatching beats are still counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_elem_cnt <= '0;
         r_beat_cnt <= '0;
      end else if (bus.start_i) begin
         r_elem_cnt <= '0;
         r_beat_cnt <= '0;
      end else if (w_accept) begin
         r_elem_cnt <= w_elem_next;
         r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
   end

   assign bus.ready_o    = (r_state == S_RUN);
   assign bus.busy_o     = (r_state == S_RUN);
   assign bus.done_o     = (r_state == S_DONE);
   assign bus.elem_cnt_o = r_elem_cnt;
   assign bus.beat_cnt_o = r_beat_cnt;
endmodule
`default_nettype wire
